// File: rtl/midi_serial_pkg.sv
// Shared FSM state types and the baud divider helper for midi_serial_bridge.
// MIDI_SERIAL_PARITY_EN adds a parity state to both the TX and RX enums.
package midi_serial_pkg;

`ifdef MIDI_SERIAL_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  // Rounded clocks-per-bit.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_ring_fifo.sv
// Ring FIFO with first-word-fall-through read, wrapping pointers and an occupancy level.
// Push while full and pop while empty are ignored; push+pop together keep the level.
module serial_ring_fifo #(
  parameter int W  = 8,
  parameter int AW = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] wr_data,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/midi_serial_bridge.sv
// Full-duplex UART bridge: TX/RX ring FIFOs with valid/ready host ports around 8N1 framing.
// Define MIDI_SERIAL_PARITY_EN to send and check one even-parity bit per frame.
module midi_serial_bridge
  import midi_serial_pkg::*;
#(
  parameter int CLK_HZ    = 53693175,
  parameter int BAUD      = 31250,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [FIFO_AW:0]     tx_level,
  output logic [FIFO_AW:0]     rx_level,
  output logic                 tx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 txd,
  input  logic                 rxd
);

  localparam int DIV  = div_calc(CLK_HZ, BAUD);
  localparam int CW   = $clog2(STOP_BITS * DIV + 1);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_load;
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;

  logic                 rx_full, rx_empty, rx_push;
  logic                 rxd_meta, rxd_sync, rxd_prev;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;

  serial_ring_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .wr_data(tx_data), .wr_en(tx_valid), .rd_en(tx_load),
    .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  serial_ring_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .wr_data(rx_shift), .wr_en(rx_push), .rd_en(rx_ready),
    .rd_data(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_busy  = (tx_state != TX_IDLE) || !tx_empty;

  // A new frame starts from IDLE or straight out of the last stop clock (back-to-back).
  assign tx_load = !tx_empty &&
                   (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == STOP_END));

`ifdef MIDI_SERIAL_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
`ifdef MIDI_SERIAL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= tx_head;
      txd      <= 1'b0;
`ifdef MIDI_SERIAL_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      case (tx_state)
        TX_START: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          txd      <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          if (tx_bit == LAST_BIT) begin
`ifdef MIDI_SERIAL_PARITY_EN
            txd      <= tx_par;
            tx_state <= TX_PARITY;
`else
            txd      <= 1'b1;
            tx_state <= TX_STOP;
`endif
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
          end
        end
`ifdef MIDI_SERIAL_PARITY_EN
        TX_PARITY: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          txd      <= 1'b1;
          tx_state <= TX_STOP;
        end
`endif
        TX_STOP: if (tx_cnt == STOP_END) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end
        default: tx_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Only the first stop bit is checked; a full RX FIFO drops the new byte, never the old ones.
  assign rx_push = (rx_state == RX_STOP) && (rx_cnt == BIT_END) && rxd_sync;

`ifndef MIDI_SERIAL_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef MIDI_SERIAL_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef MIDI_SERIAL_PARITY_EN
      parity_err <= 1'b0;
`endif
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) begin
`ifdef MIDI_SERIAL_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end
`ifdef MIDI_SERIAL_PARITY_EN
        RX_PARITY: if (rx_cnt == BIT_END) begin
          rx_cnt     <= '0;
          parity_err <= (rxd_sync != ^rx_shift);
          rx_state   <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_cnt    <= '0;
          frame_err <= !rxd_sync;
          overrun   <= rxd_sync && rx_full;
          rx_state  <= RX_IDLE;
        end
        default: begin
          rx_cnt <= '0;
          if (rxd_prev && !rxd_sync) rx_state <= RX_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_serial_bridge.sv
// Scoreboard bench for midi_serial_bridge at DIV=40 and an 8-deep FIFO:
// expected RX bytes are queued at stimulus time and compared by a separate monitor.
module tb_midi_serial_bridge;

  localparam int DIV = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] tx_level;
  logic [3:0] rx_level;
  logic       tx_busy, frame_err, parity_err, overrun, txd, rxd;
  logic       loop_en = 1'b0;
  logic       rxd_drv = 1'b1;

  assign rxd = loop_en ? txd : rxd_drv;

  midi_serial_bridge #(
    .CLK_HZ(4000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_AW(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level),
    .rx_level(rx_level), .tx_busy(tx_busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];
  int         frame_errs = 0, parity_errs = 0, overruns = 0, rx_pops = 0, rx_peak = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: counts error pulses and checks every popped RX byte against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (frame_err)  frame_errs++;
      if (parity_err) parity_errs++;
      if (overrun)    overruns++;
      if (int'(rx_level) > rx_peak) rx_peak = int'(rx_level);
      if (rx_valid && rx_ready) begin
        rx_pops++;
        if (exp_q.size() == 0) checkOutput("rx_unexpected", int'(rx_data), -1);
        else checkOutput("rx_data", int'(rx_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    for (int g = 0; g < 2000 && !tx_ready; g++) @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic driveLevel(input logic v);
    rxd_drv = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stop_bit);
    driveLevel(1'b0);
    for (int i = 0; i < 8; i++) driveLevel(b[i]);
`ifdef MIDI_SERIAL_PARITY_EN
    driveLevel(^b);
`endif
    driveLevel(stop_bit);
    driveLevel(1'b1);
  endtask

  task automatic drainRx();
    rx_ready = 1'b1;
    for (int g = 0; g < 200 && rx_valid; g++) @(negedge clk);
    repeat (2) @(negedge clk);
    rx_ready = 1'b0;
  endtask

  logic       txd_trace  [440];
  logic       busy_trace [440];
  logic [9:0] frame90 = 10'b1100100000;
  int         fe0, ov0, pops0;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_tx_level", tx_level, 0);
    checkOutput("reset_rx_level", rx_level, 0);
    checkOutput("reset_tx_busy", tx_busy, 0);
    checkOutput("reset_pulses", {frame_err, parity_err, overrun}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0x90 frame on txd, sampled every clock.
    applyStimulus(8'h90);
    checkOutput("tx_latency_1clk", txd, 1);
    @(negedge clk);
    for (int k = 0; k < 440; k++) begin
      txd_trace[k]  = txd;
      busy_trace[k] = tx_busy;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("tx_frame_bit%0d", i), txd_trace[i*DIV + DIV/2], frame90[i]);
    checkOutput("tx_low_last", txd_trace[5*DIV - 1], 0);
    checkOutput("tx_high_first", txd_trace[5*DIV], 1);
    checkOutput("tx_busy_start", busy_trace[0], 1);
    checkOutput("tx_busy_stop_end", busy_trace[10*DIV - 1], 1);
    checkOutput("tx_busy_drop", busy_trace[10*DIV], 0);
    checkOutput("tx_idle_high", txd_trace[10*DIV], 1);

    // Loopback of three back-to-back bytes.
    loop_en = 1'b1;
    rx_peak = 0;
    fe0 = frame_errs; ov0 = overruns;
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h7F);
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h7F);
    for (int g = 0; g < 3000 && rx_level != 4'd3; g++) @(negedge clk);
    repeat (DIV) @(negedge clk);
    checkOutput("loop_rx_level", rx_level, 3);
    checkOutput("loop_rx_peak", rx_peak, 3);
    checkOutput("loop_tx_idle", tx_busy, 0);
    pops0 = rx_pops;
    drainRx();
    checkOutput("loop_pops", rx_pops - pops0, 3);
    checkOutput("loop_no_errs", (frame_errs - fe0) + (overruns - ov0) + parity_errs, 0);

    // Nine frames into the 8-deep RX FIFO: the ninth overruns.
    ov0 = overruns;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      applyStimulus(8'(i));
    end
    for (int g = 0; g < 5000 && tx_busy; g++) @(negedge clk);
    repeat (DIV) @(negedge clk);
    checkOutput("ovr_rx_level_full", rx_level, 8);
    checkOutput("ovr_pulses", overruns - ov0, 1);
    pops0 = rx_pops;
    drainRx();
    checkOutput("ovr_pops", rx_pops - pops0, 8);

    // Bad stop bit, then a glitch, then a good frame.
    loop_en = 1'b0;
    fe0 = frame_errs;
    driveFrame(8'h55, 1'b0);
    checkOutput("ferr_pulse", frame_errs - fe0, 1);
    checkOutput("ferr_rx_level", rx_level, 0);
    rxd_drv = 1'b0;
    repeat (10) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitch_rx_level", rx_level, 0);
    checkOutput("glitch_no_ferr", frame_errs - fe0, 1);
    exp_q.push_back(8'hA5);
    driveFrame(8'hA5, 1'b1);
    checkOutput("after_glitch_rx_level", rx_level, 1);
    checkOutput("after_glitch_no_ferr", frame_errs - fe0, 1);
    drainRx();

`ifdef MIDI_SERIAL_PARITY_EN
    exp_q.push_back(8'h3C);
    driveLevel(1'b0);
    for (int i = 0; i < 8; i++) driveLevel(frame90[0] ^ ((8'h3C >> i) & 8'h01) != 0);
    driveLevel(1'b1);
    driveLevel(1'b1);
    driveLevel(1'b1);
    checkOutput("parity_err_pulse", parity_errs, 1);
    checkOutput("parity_byte_pushed", rx_level, 1);
    drainRx();
`endif

    // Async reset mid-transmit with bytes waiting in both FIFOs.
    exp_q.push_back(8'hC3);
    driveFrame(8'hC3, 1'b1);
    checkOutput("pre_reset_rx_level", rx_level, 1);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00);
    repeat (20) @(negedge clk);
    checkOutput("pre_reset_tx_level", tx_level, 5);
    checkOutput("pre_reset_txd_low", txd, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_txd", txd, 1);
    checkOutput("mid_reset_tx_level", tx_level, 0);
    checkOutput("mid_reset_rx_level", rx_level, 0);
    checkOutput("mid_reset_rx_valid", rx_valid, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    loop_en = 1'b1;
    pops0 = rx_pops;
    exp_q.push_back(8'h5A);
    rx_ready = 1'b1;
    applyStimulus(8'h5A);
    for (int g = 0; g < 1000 && (tx_busy || rx_pops == pops0); g++) @(negedge clk);
    repeat (5) @(negedge clk);
    checkOutput("post_reset_pops", rx_pops - pops0, 1);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
`ifndef MIDI_SERIAL_PARITY_EN
    checkOutput("parity_err_tied_low", parity_errs, 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
